apb_slave_responder: RTL

//  APB completer (slave) for the UART subsystem bench and RTL: answers transfers from an APB requester.

---
 rtl/apb_slave_responder_if.sv | 26 ++
 rtl/apb_slave_responder.sv | 119 +++++++++++
 2 files changed

// File: rtl/apb_slave_responder_if.sv
// APB bus bundle between a requester and the apb_slave_responder completer.
interface apb_slave_responder_if #(
  parameter int APB_ADDR_WIDTH = 32,
  parameter int APB_DATA_WIDTH = 32,
  parameter int APB_STRB_WIDTH = APB_DATA_WIDTH / 8
) ();
  logic                      psel;
  logic                      penable;
  logic                      pwrite;
  logic [APB_ADDR_WIDTH-1:0] paddr;
  logic [APB_DATA_WIDTH-1:0] pwdata;
  logic [APB_STRB_WIDTH-1:0] pstrb;
  logic [APB_DATA_WIDTH-1:0] prdata;
  logic                      pready;
  logic                      pslverr;

  modport master (
    output psel, penable, pwrite, paddr, pwdata, pstrb,
    input  prdata, pready, pslverr
  );

  modport slave (
    input  psel, penable, pwrite, paddr, pwdata, pstrb,
    output prdata, pready, pslverr
  );
endinterface

// File: rtl/apb_slave_responder.sv
// APB completer backed by a byte-strobed word memory, with programmable wait
// states, PSLVERR on bad addresses and a protocol-violation pulse.
module apb_slave_responder #(
  parameter int                        APB_ADDR_WIDTH = 32,
  parameter int                        APB_DATA_WIDTH = 32,
  parameter int                        APB_STRB_WIDTH = APB_DATA_WIDTH / 8,
  parameter int                        DEPTH          = 16,
  parameter logic [APB_ADDR_WIDTH-1:0] BASE_ADDR      = 32'h0
) (
  input  logic                 pclk,
  input  logic                 presetn,
  apb_slave_responder_if.slave apb,
  input  logic [3:0]           wait_cfg,
  output logic                 proto_err
);
  localparam int LSB = $clog2(APB_STRB_WIDTH);
  localparam int IW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [APB_ADDR_WIDTH-1:0] DEPTH_W    = APB_ADDR_WIDTH'(DEPTH);
  localparam logic [APB_ADDR_WIDTH-1:0] ALIGN_MASK = APB_ADDR_WIDTH'(APB_STRB_WIDTH - 1);

  localparam logic [0:0] IDLE   = 1'b0;
  localparam logic [0:0] ACCESS = 1'b1;

  logic [APB_DATA_WIDTH-1:0] mem [DEPTH];
  logic [0:0]                state;
  logic [APB_ADDR_WIDTH-1:0] addr_q;
  logic                      write_q;
  logic [APB_DATA_WIDTH-1:0] wdata_q;
  logic [APB_STRB_WIDTH-1:0] strb_q;
  logic                      err_q;
  logic [IW-1:0]             idx_q;
  logic [3:0]                cnt;
  logic [APB_DATA_WIDTH-1:0] rdata_q;

  logic [APB_ADDR_WIDTH-1:0] offset;
  logic [APB_ADDR_WIDTH-1:0] word;
  logic [IW-1:0]             idx;
  logic                      decode_err;
  logic                      mismatch;
  logic                      ready;

  assign offset     = apb.paddr - BASE_ADDR;
  assign word       = offset >> LSB;
  assign idx        = word[IW-1:0];
  assign decode_err = (apb.paddr < BASE_ADDR) || (word >= DEPTH_W) ||
                      ((apb.paddr & ALIGN_MASK) != '0);

  assign mismatch = (apb.paddr != addr_q) || (apb.pwrite != write_q) ||
                    (apb.pwdata != wdata_q) || (apb.pstrb != strb_q);

  assign ready       = (state == ACCESS) && apb.penable && (cnt == 4'd0);
  assign apb.pready  = ready;
  assign apb.pslverr = ready & err_q;
  assign apb.prdata  = ready ? rdata_q : '0;

  // Read data is captured at setup so wait states cannot expose later writes.
  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      state     <= IDLE;
      addr_q    <= '0;
      write_q   <= 1'b0;
      wdata_q   <= '0;
      strb_q    <= '0;
      err_q     <= 1'b0;
      idx_q     <= '0;
      cnt       <= 4'd0;
      rdata_q   <= '0;
      proto_err <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else begin
      proto_err <= 1'b0;
      case (state)
        IDLE: begin
          if (apb.psel && !apb.penable) begin
            addr_q  <= apb.paddr;
            write_q <= apb.pwrite;
            wdata_q <= apb.pwdata;
            strb_q  <= apb.pstrb;
            err_q   <= decode_err;
            idx_q   <= idx;
            cnt     <= wait_cfg;
            rdata_q <= (decode_err || apb.pwrite) ? '0 : mem[idx];
            state   <= ACCESS;
          end else if (apb.psel && apb.penable) begin
            proto_err <= 1'b1;
          end
        end
        ACCESS: begin
          if (!apb.psel) begin
            proto_err <= 1'b1;
            state     <= IDLE;
          end else if (!apb.penable) begin
            proto_err <= 1'b1;
          end else begin
            // A requester changing its request is flagged but the latched copy wins.
            if (mismatch) begin
              proto_err <= 1'b1;
            end
            if (cnt != 4'd0) begin
              cnt <= cnt - 4'd1;
            end else begin
              if (write_q && !err_q) begin
                for (int b = 0; b < APB_STRB_WIDTH; b++) begin
                  if (strb_q[b]) begin
                    mem[idx_q][8*b +: 8] <= wdata_q[8*b +: 8];
                  end
                end
              end
              state <= IDLE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
